// File: rtl/scan_session_ctrl.sv
// Full-scan session sequencer: fetches pattern/expect pairs, shifts them through the chain,
// runs capture clocks and compares each unloaded response against its expected value.
module scan_session_ctrl #(
    parameter int CHAIN_LEN = 17,
    parameter int CAP_W     = 7,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    input  logic [CAP_W-1:0]     pat_cap,
    input  logic                 pat_last,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 test_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     pat_count,
    output logic [CNT_W-1:0]     first_fail_idx
);

    localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        CMP,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] shift_r;
    logic [CHAIN_LEN-1:0] resp_r;
    logic [CHAIN_LEN-1:0] exp_next;
    logic [CHAIN_LEN-1:0] exp_prev;
    logic [CAP_W-1:0]     cap_r;
    logic [CAP_W-1:0]     cap_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 last_r;
    logic                 have_prev;
    logic                 unload_r;

    logic [CAP_W-1:0]     cap_eff;
    logic                 shift_last;
    logic                 cap_last;

    // A programmed capture count of zero still gets one functional clock.
    assign cap_eff    = (cap_r == '0) ? CAP_W'(1) : cap_r;
    assign shift_last = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
    assign cap_last   = (cap_cnt == cap_eff - CAP_W'(1));

    // The stimulus register feeds the chain directly, so scan_in is a flop output.
    assign scan_in = shift_r[0];
    assign busy    = test_mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: every register below is updated with <= so all reads in this block see
    // pre-edge values; the chain-wide registers are reset too, since a reset must
    // leave no stale response that a later session could compare against.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            shift_r        <= '0;
            resp_r         <= '0;
            exp_next       <= '0;
            exp_prev       <= '0;
            cap_r          <= '0;
            cap_cnt        <= '0;
            bit_cnt        <= '0;
            last_r         <= 1'b0;
            have_prev      <= 1'b0;
            unload_r       <= 1'b0;
            pat_ready      <= 1'b0;
            scan_en        <= 1'b0;
            test_mode      <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_count     <= '0;
            pat_count      <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= FETCH;
                        pat_ready      <= 1'b1;
                        test_mode      <= 1'b1;
                        done           <= 1'b0;
                        fail           <= 1'b0;
                        fail_count     <= '0;
                        pat_count      <= '0;
                        first_fail_idx <= '0;
                        have_prev      <= 1'b0;
                        unload_r       <= 1'b0;
                    end
                end

                FETCH: begin
                    if (pat_valid && pat_ready) begin
                        shift_r   <= pat_data;
                        exp_next  <= pat_expect;
                        cap_r     <= pat_cap;
                        last_r    <= pat_last;
                        pat_count <= sat_inc(pat_count);
                        bit_cnt   <= '0;
                        pat_ready <= 1'b0;
                        scan_en   <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT, UNLOAD: begin
                    // Response bits arrive MSB-first into the register, so the first
                    // bit out of the chain lands in resp_r[0] after a full pass.
                    shift_r <= {1'b0, shift_r[CHAIN_LEN-1:1]};
                    resp_r  <= {scan_out, resp_r[CHAIN_LEN-1:1]};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (shift_last) begin
                        scan_en <= 1'b0;
                        if (have_prev) begin
                            state <= CMP;
                        end else begin
                            cap_cnt <= '0;
                            state   <= CAPTURE;
                        end
                    end
                end

                CMP: begin
                    if (resp_r != exp_prev) begin
                        fail       <= 1'b1;
                        fail_count <= sat_inc(fail_count);
                        // In a normal pass the response belongs to the pattern before the
                        // one just loaded; in the unload pass it is the latest one.
                        if (!fail) begin
                            first_fail_idx <= unload_r ? pat_count - CNT_W'(1)
                                                       : pat_count - CNT_W'(2);
                        end
                    end
                    if (unload_r) begin
                        done      <= 1'b1;
                        test_mode <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cap_cnt <= '0;
                        state   <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    cap_cnt <= cap_cnt + CAP_W'(1);
                    if (cap_last) begin
                        exp_prev  <= exp_next;
                        have_prev <= 1'b1;
                        if (last_r) begin
                            unload_r <= 1'b1;
                            shift_r  <= '0;
                            bit_cnt  <= '0;
                            scan_en  <= 1'b1;
                            state    <= UNLOAD;
                        end else begin
                            pat_ready <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_session_ctrl.sv
// Scoreboard bench for scan_session_ctrl: an echoing chain model, directed sessions, and a
// monitor that checks every shifted bit and each session's statistics when done rises.
module tb_scan_session_ctrl;

    localparam int L     = 4;
    localparam int CAP_W = 7;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             pat_valid;
    logic             pat_ready;
    logic [L-1:0]     pat_data;
    logic [L-1:0]     pat_expect;
    logic [CAP_W-1:0] pat_cap;
    logic             pat_last;
    logic             scan_en;
    logic             scan_in;
    logic             scan_out;
    logic             test_mode;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] pat_count;
    logic [CNT_W-1:0] first_fail_idx;

    always #5 clk = ~clk;

    scan_session_ctrl #(.CHAIN_LEN(L), .CAP_W(CAP_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pat_valid      (pat_valid),
        .pat_ready      (pat_ready),
        .pat_data       (pat_data),
        .pat_expect     (pat_expect),
        .pat_cap        (pat_cap),
        .pat_last       (pat_last),
        .scan_en        (scan_en),
        .scan_in        (scan_in),
        .scan_out       (scan_out),
        .test_mode      (test_mode),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .fail_count     (fail_count),
        .pat_count      (pat_count),
        .first_fail_idx (first_fail_idx)
    );

    // Chain model: capture leaves the contents untouched, so each response echoes its stimulus.
    logic [L-1:0] chain = '0;
    always @(posedge clk) if (scan_en) chain <= {scan_in, chain[L-1:1]};
    assign scan_out = chain[0];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             fail;
        logic [CNT_W-1:0] fc;
        logic [CNT_W-1:0] pc;
        logic [CNT_W-1:0] ffi;
        int               cycles;
        int               passes;
    } sess_t;

    sess_t sess_q[$];
    logic  bit_q[$];
    int    busy_cycles  = 0;
    int    shift_passes = 0;

    logic [L-1:0]     pd[32];
    logic [L-1:0]     pe[32];
    logic [CAP_W-1:0] pcap[32];

    // Monitor: consumes expected scan_in bits and session results as the DUT presents them.
    initial begin
        logic  scan_en_q = 1'b0;
        logic  done_q    = 1'b0;
        logic  b;
        sess_t s;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (scan_en) begin
                    if (bit_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL shift_unexpected: scan_en high with no pattern bit queued");
                    end else begin
                        b = bit_q.pop_front();
                        check("scan_in_bit", scan_in, b);
                    end
                    if (!scan_en_q) shift_passes++;
                end
                if (busy && !pat_ready) busy_cycles++;
                if (done && !done_q) begin
                    if (sess_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL done_unexpected: done rose with no session queued");
                    end else begin
                        s = sess_q.pop_front();
                        check("sess_fail",           fail,           s.fail);
                        check("sess_fail_count",     fail_count,     s.fc);
                        check("sess_pat_count",      pat_count,      s.pc);
                        check("sess_first_fail_idx", first_fail_idx, s.ffi);
                        check("sess_busy_cycles",    busy_cycles,    s.cycles);
                        check("sess_shift_passes",   shift_passes,   s.passes);
                        check("sess_test_mode_low",  test_mode,      1'b0);
                    end
                end
            end
            scan_en_q = scan_en;
            done_q    = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        busy_cycles  = 0;
        shift_passes = 0;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!pat_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (!pat_ready) check("pat_ready_timeout", pat_ready, 1'b1);
    endtask

    task automatic push_bits(input logic [L-1:0] v);
        for (int k = 0; k < L; k++) bit_q.push_back(v[k]);
    endtask

    // Runs one session of n patterns; optionally stalls the source before pattern stall_at
    // and pulses start while busy after the first pattern is accepted.
    task automatic run_session(input int n, input int stall_at, input bit poke_busy);
        sess_t            s;
        int               fc;
        int               cap_sum;
        logic [CNT_W-1:0] c0;
        int               c;
        fc        = 0;
        cap_sum   = 0;
        s.fail    = 1'b0;
        s.ffi     = '0;
        for (int i = 0; i < n; i++) begin
            cap_sum += (pcap[i] == 0) ? 1 : int'(pcap[i]);
            if (pe[i] != pd[i]) begin
                if (!s.fail) s.ffi = CNT_W'(i);
                s.fail = 1'b1;
                if (fc < 15) fc++;
            end
        end
        s.fc     = CNT_W'(fc);
        s.pc     = CNT_W'((n < 15) ? n : 15);
        s.cycles = (n + 1) * L + cap_sum + n;
        s.passes = n + 1;

        pulse_start();
        check("stats_cleared_on_start",
              {done, fail, fail_count, pat_count, first_fail_idx}, 32'd0);
        check("busy_after_start", {busy, test_mode}, 2'b11);

        for (int i = 0; i < n; i++) begin
            wait_ready();
            if (i == stall_at) begin
                c0 = pat_count;
                for (int k = 0; k < 10; k++) begin
                    check("stall_pat_ready", pat_ready, 1'b1);
                    check("stall_scan_en",   scan_en,   1'b0);
                    check("stall_pat_count", pat_count, c0);
                    @(negedge clk);
                end
            end
            push_bits(pd[i]);
            if (i == n - 1) begin
                push_bits('0);
                sess_q.push_back(s);
            end
            pat_valid  = 1'b1;
            pat_data   = pd[i];
            pat_expect = pe[i];
            pat_cap    = pcap[i];
            pat_last   = (i == n - 1);
            @(negedge clk);
            pat_valid = 1'b0;
            pat_last  = 1'b0;
            check("pat_ready_after_accept", pat_ready, 1'b0);
            if (poke_busy && i == 0) begin
                c0    = pat_count;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_while_busy", {busy, scan_en, pat_count}, {2'b11, c0});
            end
        end

        c = 0;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (!done) check("done_timeout", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        pat_valid  = 1'b0;
        pat_data   = '0;
        pat_expect = '0;
        pat_cap    = '0;
        pat_last   = 1'b0;
        #1;
        check("reset_outputs",
              {scan_en, scan_in, pat_ready, test_mode, busy, done, fail,
               fail_count, pat_count, first_fail_idx}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {scan_en, pat_ready, busy, done}, 4'b0000);

        // Single passing pattern, scan_in 1,1,0,1 then zeros during unload.
        pd[0] = 4'b1011; pe[0] = 4'b1011; pcap[0] = 7'd2;
        run_session(1, -1, 1'b0);

        // Same pattern with a wrong expectation; done and fail hold afterwards.
        pe[0] = 4'b0000;
        run_session(1, -1, 1'b0);
        repeat (5) @(negedge clk);
        check("done_held", {done, fail, busy}, 3'b110);

        // Three patterns, only the second mismatches; source stalls before the second.
        pd[0] = 4'b1011; pe[0] = 4'b1011; pcap[0] = 7'd3;
        pd[1] = 4'b0110; pe[1] = 4'b0111; pcap[1] = 7'd1;
        pd[2] = 4'b1100; pe[2] = 4'b1100; pcap[2] = 7'd0;
        run_session(3, 1, 1'b0);

        // Reset during the second shift cycle of a session.
        pulse_start();
        wait_ready();
        push_bits(4'b1001);
        pat_valid  = 1'b1;
        pat_data   = 4'b1001;
        pat_expect = 4'b1001;
        pat_cap    = 7'd1;
        pat_last   = 1'b1;
        @(negedge clk);
        pat_valid = 1'b0;
        pat_last  = 1'b0;
        check("shift_active_before_reset", scan_en, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_mid_shift_outputs",
              {scan_en, scan_in, pat_ready, test_mode, busy, done, fail,
               fail_count, pat_count, first_fail_idx}, 32'd0);
        bit_q.delete();
        @(negedge clk);
        reset = 1'b1;

        // Clean session after reset: capture count 0 runs one clock; start while busy is ignored.
        pd[0] = 4'b0101; pe[0] = 4'b0101; pcap[0] = 7'd0;
        run_session(1, -1, 1'b1);

        // Seventeen failing patterns saturate both 4-bit counters.
        for (int i = 0; i < 17; i++) begin
            pd[i]   = 4'(i * 5 + 3);
            pe[i]   = ~pd[i];
            pcap[i] = 7'd1;
        end
        run_session(17, -1, 1'b0);

        repeat (3) @(negedge clk);
        check("sessions_drained", sess_q.size(), 32'd0);
        check("bits_drained",     bit_q.size(),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
